uart_rx_core: RTL and testbench

Serial-to-parallel UART receiver. Oversamples the asynchronous `rx_i` line, validates start and stop bits, assembles an 8-bit LSB-first character, and presents it with a single-cycle `rx_data_rdy_o` strobe. Sits directly upstream of the receive control FSM, which loads `rx_data_o` into the data register and raises the control register's "new" flag.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_rx_core_if.sv | 27 ++
 rtl/uart_baud_tick.sv | 32 +++
 rtl/uart_rx_core.sv | 192 +++++++++++++++++++
 tb/tb_uart_rx_core.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding, oversampling
// constants and the three-sample majority vote.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned TICK_W     = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_CNT_W  = $clog2(DATA_BITS);

  // Sample points within a bit; the decision is taken on the last of the three.
  localparam int unsigned TICK_SAMPLE_A = OVERSAMPLE / 2 - 1;
  localparam int unsigned TICK_SAMPLE_B = OVERSAMPLE / 2;
  localparam int unsigned TICK_DECIDE   = OVERSAMPLE / 2 + 1;
  localparam int unsigned TICK_LAST     = OVERSAMPLE - 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_core_if.sv
// Receive-side character interface between uart_rx_core (master) and the
// receive control FSM (slave).
interface uart_rx_core_if;

  logic [7:0] rx_data_o;
  logic       rx_data_rdy_o;
  logic       frame_err_o;
  logic       parity_err_o;
  logic       busy_o;

  modport master (
    output rx_data_o,
    output rx_data_rdy_o,
    output frame_err_o,
    output parity_err_o,
    output busy_o
  );

  modport slave (
    input rx_data_o,
    input rx_data_rdy_o,
    input frame_err_o,
    input parity_err_o,
    input busy_o
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Free-running divider: tick pulses for one clock every DIV clocks.
// Shared by the receive and transmit sides.
module uart_baud_tick #(
  parameter int unsigned DIV = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  if (DIV < 2) begin : g_div_check
    $error("uart_baud_tick: DIV must be at least 2");
  end

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else if (cnt_q == CNT_W'(DIV - 1)) begin
      cnt_q <= '0;
      tick  <= 1'b1;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: 16x oversampled, majority-voted, 8N1 by default or 8E1 when
// UART_RX_PARITY_EN is defined. Delivers characters as single-cycle strobes.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD_RATE = 115_200
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           rx_i,
  uart_rx_core_if.master rx_bus
);

  localparam int unsigned DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);

  rx_state_t              state_q;
  logic                   rx_meta_q;
  logic                   rx_sync_q;
  logic                   tick;
  logic [TICK_W-1:0]      tick_cnt_q;
  logic [BIT_CNT_W-1:0]   bit_cnt_q;
  logic [1:0]             samp_q;
  logic [DATA_BITS-1:0]   shreg_q;
  logic                   par_err_q;
  logic [DATA_BITS-1:0]   rx_data_q;
  logic                   rdy_q;
  logic                   frame_err_q;
  logic                   parity_err_q;
  logic                   busy_q;

  logic in_bit_c;
  logic at_decide_c;
  logic at_last_c;
  logic bit_val_c;

  // Two-flop synchronizer; resets to the idle line level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
    end
  end

  uart_baud_tick #(
    .DIV (DIV)
  ) u_baud_tick (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .tick   (tick)
  );

  assign in_bit_c    = (state_q == START) || (state_q == DATA) ||
                       (state_q == PARITY) || (state_q == STOP);
  assign at_decide_c = in_bit_c && tick && (tick_cnt_q == TICK_W'(TICK_DECIDE));
  assign at_last_c   = in_bit_c && tick && (tick_cnt_q == TICK_W'(TICK_LAST));
  assign bit_val_c   = majority3(samp_q[0], samp_q[1], rx_sync_q);

  // Per-bit oversample counter, realigned to each detected start edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tick_cnt_q <= '0;
    end else if ((state_q == IDLE) && !rx_sync_q) begin
      tick_cnt_q <= '0;
    end else if (in_bit_c && tick) begin
      tick_cnt_q <= tick_cnt_q + TICK_W'(1);
    end
  end

  // Early samples for the vote; the third is the live line at the decision tick.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      samp_q <= 2'b11;
    end else if (in_bit_c && tick) begin
      if (tick_cnt_q == TICK_W'(TICK_SAMPLE_A)) samp_q[0] <= rx_sync_q;
      if (tick_cnt_q == TICK_W'(TICK_SAMPLE_B)) samp_q[1] <= rx_sync_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      par_err_q    <= 1'b0;
      rx_data_q    <= '0;
      rdy_q        <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      rdy_q        <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (!rx_sync_q) begin
            state_q   <= START;
            bit_cnt_q <= '0;
            par_err_q <= 1'b0;
            busy_q    <= 1'b1;
          end
        end

        // A start bit that votes high was a glitch.
        START: begin
          if (at_decide_c && bit_val_c) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (at_last_c) begin
            state_q <= DATA;
          end
        end

        DATA: begin
          if (at_decide_c) begin
            shreg_q <= {bit_val_c, shreg_q[DATA_BITS-1:1]};
          end
          if (at_last_c) begin
            if (bit_cnt_q == BIT_CNT_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end else begin
              bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        // Even parity: the parity bit must equal the XOR of the data bits.
        PARITY: begin
          if (at_decide_c) begin
            par_err_q <= bit_val_c ^ (^shreg_q);
          end
          if (at_last_c) begin
            state_q <= STOP;
          end
        end
`endif

        // Leave mid-stop-bit so an immediately following start is not missed.
        STOP: begin
          if (at_decide_c) begin
            if (!bit_val_c) begin
              frame_err_q <= 1'b1;
              state_q     <= BREAK;
            end else begin
              if (par_err_q) begin
                parity_err_q <= 1'b1;
              end else begin
                rx_data_q <= shreg_q;
                rdy_q     <= 1'b1;
              end
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end

        BREAK: begin
          if (rx_sync_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_bus.rx_data_o     = rx_data_q;
  assign rx_bus.rx_data_rdy_o = rdy_q;
  assign rx_bus.frame_err_o   = frame_err_q;
  assign rx_bus.busy_o        = busy_q;
`ifdef UART_RX_PARITY_EN
  assign rx_bus.parity_err_o  = parity_err_q;
`else
  assign rx_bus.parity_err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: directed frames plus random traffic checked against a
// frame-level reference model. Honors UART_RX_PARITY_EN like the design.
module tb_uart_rx_core;

  localparam int unsigned CLK_FREQ  = 1_600_000;
  localparam int unsigned BAUD_RATE = 10_000;
  localparam int unsigned BIT_CLKS  = CLK_FREQ / BAUD_RATE;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rx    = 1'b1;

  uart_rx_core_if rx_bus ();

  uart_rx_core #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .rx_i   (rx),
    .rx_bus (rx_bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Observed side: strobes and delivered characters.
  int          cyc = 0;
  int          n_rdy = 0, n_ferr = 0, n_perr = 0;
  logic [7:0]  got_q[$];
  int          rdy_cyc_q[$];
  logic        prev_rdy  = 1'b0;
  logic [7:0]  prev_data = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_bus.rx_data_rdy_o === 1'b1) begin
      n_rdy++;
      got_q.push_back(rx_bus.rx_data_o);
      rdy_cyc_q.push_back(cyc);
      check("rdy_one_cycle", 32'(prev_rdy), 32'd0);
    end
    if (rx_bus.frame_err_o === 1'b1)  n_ferr++;
    if (rx_bus.parity_err_o === 1'b1) n_perr++;
    if (rx_bus.rx_data_rdy_o | rx_bus.frame_err_o | rx_bus.parity_err_o)
      check("one_strobe", 32'(rx_bus.rx_data_rdy_o) + 32'(rx_bus.frame_err_o) +
            32'(rx_bus.parity_err_o), 32'd1);
    if (rst_n && (rx_bus.rx_data_o !== prev_data))
      check("data_only_on_rdy", 32'(rx_bus.rx_data_rdy_o), 32'd1);
    prev_rdy  = rx_bus.rx_data_rdy_o;
    prev_data = rx_bus.rx_data_o;
  end

  // Reference model: outcome of each frame from its stop and parity bits.
  int          exp_rdy = 0, exp_ferr = 0, exp_perr = 0;
  logic [7:0]  exp_data = 8'h00;
  logic [7:0]  exp_q[$];

  task automatic model_frame(input logic [7:0] d, input logic stop_ok, input logic par_ok);
    if (!stop_ok) exp_ferr++;
    else if (PAR_EN && !par_ok) exp_perr++;
    else begin
      exp_rdy++;
      exp_data = d;
      exp_q.push_back(d);
    end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_ok, input logic par_ok);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (PAR_EN) drive_bit(par_ok ? ^d : ~^d);
    drive_bit(stop_ok);
    model_frame(d, stop_ok, par_ok);
  endtask

  task automatic wait_idle(input int max_clks);
    int k = 0;
    while (rx_bus.busy_o !== 1'b0 && k < max_clks) begin
      @(negedge clk);
      k++;
    end
    check("busy_low", 32'(rx_bus.busy_o), 32'd0);
  endtask

  task automatic check_totals(input string tag);
    check({tag, "_rdy"},  32'(n_rdy),  32'(exp_rdy));
    check({tag, "_ferr"}, 32'(n_ferr), 32'(exp_ferr));
    check({tag, "_perr"}, 32'(n_perr), 32'(exp_perr));
    check({tag, "_data"}, 32'(rx_bus.rx_data_o), 32'(exp_data));
  endtask

  initial begin
    logic [7:0] d;
    logic       stop_ok, par_ok;
    int         gap, dt;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({rx_bus.rx_data_o, rx_bus.rx_data_rdy_o, rx_bus.frame_err_o,
                                rx_bus.parity_err_o, rx_bus.busy_o}), 32'd0);
    rst_n = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);

    // Single good character
    send_frame(8'hA5, 1'b1, 1'b1);
    wait_idle(400);
    check_totals("a5");

    // Back-to-back characters, no idle gap
    send_frame(8'h3C, 1'b1, 1'b1);
    send_frame(8'hC3, 1'b1, 1'b1);
    wait_idle(400);
    check_totals("b2b");
    dt = (rdy_cyc_q.size() >= 2) ? rdy_cyc_q[rdy_cyc_q.size()-1] - rdy_cyc_q[rdy_cyc_q.size()-2] : 0;
    check("b2b_spacing", 32'(dt >= int'(BIT_CLKS * (8 + PAR_EN + 2)) - 2 &&
                              dt <= int'(BIT_CLKS * (8 + PAR_EN + 2)) + 2), 32'd1);

    // Short low glitch on an idle line
    rx = 1'b0;
    repeat (40) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    wait_idle(10);
    check_totals("glitch");

    // Stop bit low, line held low afterwards: stays busy until the line rises
    send_frame(8'h55, 1'b0, 1'b1);
    repeat (3 * BIT_CLKS) @(negedge clk);
    check("break_busy", 32'(rx_bus.busy_o), 32'd1);
    check_totals("ferr");
    rx = 1'b1;
    wait_idle(50);
    repeat (BIT_CLKS) @(negedge clk);
    check_totals("after_break");

    // Reset in the middle of data bit 4 of 8'hFF
    drive_bit(1'b0);
    rx = 1'b1;
    repeat (4 * BIT_CLKS + BIT_CLKS / 2) @(negedge clk);
    check("busy_mid_frame", 32'(rx_bus.busy_o), 32'd1);
    rst_n = 1'b0;
    exp_data = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_mid_outputs", 32'({rx_bus.rx_data_o, rx_bus.rx_data_rdy_o, rx_bus.frame_err_o,
                                    rx_bus.parity_err_o, rx_bus.busy_o}), 32'd0);
    end
    rst_n = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    check_totals("post_reset");
    send_frame(8'h12, 1'b1, 1'b1);
    wait_idle(400);
    check_totals("x12");

    if (PAR_EN) begin
      send_frame(8'h07, 1'b1, 1'b1);
      wait_idle(400);
      check_totals("par_good");
      send_frame(8'h07, 1'b1, 1'b0);
      wait_idle(400);
      check_totals("par_bad");
    end

    // Random traffic
    for (int f = 0; f < 14; f++) begin
      d       = 8'($urandom);
      stop_ok = ($urandom_range(0, 4) != 0);
      par_ok  = ($urandom_range(0, 3) != 0);
      send_frame(d, stop_ok, par_ok);
      if (!stop_ok) begin
        rx  = 1'b1;
        gap = 40 + $urandom_range(0, 100);
      end else begin
        gap = $urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 200);
      end
      repeat (gap) @(negedge clk);
    end
    rx = 1'b1;
    wait_idle(2 * BIT_CLKS);
    repeat (BIT_CLKS) @(negedge clk);
    check_totals("random");
    check("char_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check("char_seq", 32'(got_q[i]), 32'(exp_q[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
